// File: rtl/alu_share_arb_pkg.sv
// Shared definitions for alu_share_arb: ALU control codes, FSM states, flag bit positions.
package alu_share_arb_pkg;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned FLAG_W = 4;

  localparam logic [2:0] CTRL_ADD = 3'b000;
  localparam logic [2:0] CTRL_SUB = 3'b001;
  localparam logic [2:0] CTRL_AND = 3'b010;
  localparam logic [2:0] CTRL_OR  = 3'b011;
  localparam logic [2:0] CTRL_XOR = 3'b100;
  localparam logic [2:0] CTRL_SLT = 3'b101;

  localparam int unsigned FLAG_Z = 3;
  localparam int unsigned FLAG_N = 2;
  localparam int unsigned FLAG_C = 1;
  localparam int unsigned FLAG_V = 0;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  typedef struct packed {
    logic [DATA_W-1:0] a;
    logic [DATA_W-1:0] b;
    logic [2:0]        ctrl;
  } op_t;

endpackage

// File: rtl/alu_share_arb_alu.sv
// Team 32-bit ALU, purely combinational (0 cycles, no backpressure).
// Flags {Z,N,C,V}; C is carry-out / no-borrow, and C and V are 0 for logic, slt and unused codes.
module alu_share_arb_alu
  import alu_share_arb_pkg::*;
(
  input  logic [DATA_W-1:0] i_a,
  input  logic [DATA_W-1:0] i_b,
  input  logic [2:0]        i_ctrl,
  output logic [DATA_W-1:0] o_result,
  output logic [FLAG_W-1:0] o_flags
);

  logic [DATA_W:0]   w_sum;
  logic [DATA_W:0]   w_diff;
  logic [DATA_W-1:0] w_res;
  logic              w_c;
  logic              w_v;

  assign w_sum  = {1'b0, i_a} + {1'b0, i_b};
  assign w_diff = {1'b0, i_a} + {1'b0, ~i_b} + {{DATA_W{1'b0}}, 1'b1};

  always_comb begin
    w_res = '0;
    w_c   = 1'b0;
    w_v   = 1'b0;
    case (i_ctrl)
      CTRL_ADD: begin
        w_res = w_sum[DATA_W-1:0];
        w_c   = w_sum[DATA_W];
        w_v   = (i_a[DATA_W-1] == i_b[DATA_W-1]) && (w_res[DATA_W-1] != i_a[DATA_W-1]);
      end
      CTRL_SUB: begin
        w_res = w_diff[DATA_W-1:0];
        w_c   = w_diff[DATA_W];
        w_v   = (i_a[DATA_W-1] != i_b[DATA_W-1]) && (w_res[DATA_W-1] != i_a[DATA_W-1]);
      end
      CTRL_AND: w_res = i_a & i_b;
      CTRL_OR:  w_res = i_a | i_b;
      CTRL_XOR: w_res = i_a ^ i_b;
      CTRL_SLT: w_res = {{(DATA_W-1){1'b0}}, ($signed(i_a) < $signed(i_b))};
      default:  w_res = '0;
    endcase
  end

  always_comb begin
    o_result        = w_res;
    o_flags         = '0;
    o_flags[FLAG_Z] = ~|w_res;
    o_flags[FLAG_N] = w_res[DATA_W-1];
    o_flags[FLAG_C] = w_c;
    o_flags[FLAG_V] = w_v;
  end

endmodule

// File: rtl/alu_share_arb.sv
// Two requesters share one ALU (round-robin ties; requester 0 always wins ties with ALU_SHARE_FIXED_PRIO_EN).
// Accept -> rsp_valid in 2 cycles, 3-cycle issue interval; result held until the granted requester's rsp_ready.
module alu_share_arb
  import alu_share_arb_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic [1:0]        req_valid,
  output logic [1:0]        req_ready,
  input  logic [DATA_W-1:0] req_a0,
  input  logic [DATA_W-1:0] req_b0,
  input  logic [DATA_W-1:0] req_a1,
  input  logic [DATA_W-1:0] req_b1,
  input  logic [2:0]        req_ctrl0,
  input  logic [2:0]        req_ctrl1,
  output logic [1:0]        rsp_valid,
  input  logic [1:0]        rsp_ready,
  output logic [DATA_W-1:0] rsp_result,
  output logic [FLAG_W-1:0] rsp_flags,
  output logic              busy
);

  state_t            r_state;
  state_t            w_next;
  op_t               r_op;
  op_t               w_op;
  logic              r_gnt;
  logic              w_gnt;
  logic              w_accept;
  logic              w_rsp_done;
  logic [DATA_W-1:0] w_alu_res;
  logic [FLAG_W-1:0] w_alu_flags;

`ifndef ALU_SHARE_FIXED_PRIO_EN
  logic r_last_gnt;
`endif

  always_comb begin
    w_gnt = req_valid[1];
    if (req_valid == 2'b11) begin
`ifdef ALU_SHARE_FIXED_PRIO_EN
      w_gnt = 1'b0;
`else
      w_gnt = ~r_last_gnt;
`endif
    end
    w_op       = w_gnt ? '{a: req_a1, b: req_b1, ctrl: req_ctrl1}
                       : '{a: req_a0, b: req_b0, ctrl: req_ctrl0};
    // rst_n gates the accept so req_ready stays low while reset is held
    w_accept   = rst_n && (r_state == ST_IDLE) && (|req_valid);
    w_rsp_done = (r_state == ST_RESP) && rsp_ready[r_gnt];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE: if (w_accept) w_next = ST_EXEC;
      ST_EXEC: w_next = ST_RESP;
      ST_RESP: if (w_rsp_done) w_next = ST_IDLE;
      default: w_next = ST_IDLE;
    endcase
  end

  always_comb begin
    req_ready = 2'b00;
    rsp_valid = 2'b00;
    busy      = (r_state != ST_IDLE);
    if (w_accept) req_ready[w_gnt] = 1'b1;
    if (r_state == ST_RESP) rsp_valid[r_gnt] = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_op       <= '0;
      r_gnt      <= 1'b0;
      rsp_result <= '0;
      rsp_flags  <= '0;
    end else begin
      if (w_accept) begin
        r_op  <= w_op;
        r_gnt <= w_gnt;
      end
      if (r_state == ST_EXEC) begin
        rsp_result <= w_alu_res;
        rsp_flags  <= w_alu_flags;
      end
    end
  end

`ifndef ALU_SHARE_FIXED_PRIO_EN
  // Reset value 1 hands the first tie to requester 0
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_last_gnt <= 1'b1;
    end else if (w_rsp_done) begin
      r_last_gnt <= ~r_last_gnt;
    end
  end
`endif

  alu_share_arb_alu u_alu (
    .i_a      (r_op.a),
    .i_b      (r_op.b),
    .i_ctrl   (r_op.ctrl),
    .o_result (w_alu_res),
    .o_flags  (w_alu_flags)
  );

endmodule

// File: tb/tb_alu_share_arb.sv
// Bench for alu_share_arb: directed cases then random ops against a behavioural ALU/arbiter model.
module tb_alu_share_arb;

  logic        clk;
  logic        rst_n;
  logic [1:0]  req_valid;
  logic [1:0]  req_ready;
  logic [31:0] req_a0, req_b0, req_a1, req_b1;
  logic [2:0]  req_ctrl0, req_ctrl1;
  logic [1:0]  rsp_valid;
  logic [1:0]  rsp_ready;
  logic [31:0] rsp_result;
  logic [3:0]  rsp_flags;
  logic        busy;

  int n_checks = 0;
  int n_errors = 0;
  int n_done   = 0;   // responses completed since last reset

  alu_share_arb dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_a0     (req_a0),
    .req_b0     (req_b0),
    .req_a1     (req_a1),
    .req_b1     (req_b1),
    .req_ctrl0  (req_ctrl0),
    .req_ctrl1  (req_ctrl1),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_result (rsp_result),
    .rsp_flags  (rsp_flags),
    .busy       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Returns {result[31:0], Z, N, C, V}
  function automatic logic [35:0] ref_alu(input logic [2:0] ctrl, input logic [31:0] a, input logic [31:0] b);
    longint      sa, sb, ua, ub;
    logic [31:0] r;
    logic        c, v;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = longint'({32'd0, a});
    ub = longint'({32'd0, b});
    c  = 1'b0;
    v  = 1'b0;
    case (ctrl)
      3'd0: begin r = a + b; c = ((ua + ub) >> 32) != 0; v = (sa + sb) != longint'($signed(r)); end
      3'd1: begin r = a - b; c = (a >= b);               v = (sa - sb) != longint'($signed(r)); end
      3'd2: r = a & b;
      3'd3: r = a | b;
      3'd4: r = a ^ b;
      3'd5: r = (sa < sb) ? 32'd1 : 32'd0;
      default: r = 32'd0;
    endcase
    return {r, (r == 32'd0), r[31], c, v};
  endfunction

  function automatic logic exp_grant(input logic [1:0] v);
    logic last;
    last = 1'b1 ^ n_done[0];
    if (v == 2'b11) begin
`ifdef ALU_SHARE_FIXED_PRIO_EN
      return 1'b0;
`else
      return ~last;
`endif
    end
    return v[1];
  endfunction

  function automatic logic [1:0] onehot(input logic g);
    return g ? 2'b10 : 2'b01;
  endfunction

  task automatic do_reset();
    @(negedge clk);
    rst_n     = 1'b0;
    req_valid = 2'b11;
    rsp_ready = 2'b00;
    #1;
    check("rst_req_ready", req_ready, 2'b00);
    check("rst_rsp_valid", rsp_valid, 2'b00);
    check("rst_result", rsp_result, 32'd0);
    check("rst_flags", rsp_flags, 4'd0);
    check("rst_busy", busy, 1'b0);
    @(negedge clk);
    rst_n     = 1'b1;
    req_valid = 2'b00;
    n_done    = 0;
  endtask

  // Drives one request and checks through to the first RESP cycle
  task automatic issue(input logic [1:0] v,
                       input logic [31:0] a0, input logic [31:0] b0, input logic [2:0] c0,
                       input logic [31:0] a1, input logic [31:0] b1, input logic [2:0] c1,
                       output logic g, output logic [35:0] e);
    @(negedge clk);
    req_valid = v;
    req_a0 = a0; req_b0 = b0; req_ctrl0 = c0;
    req_a1 = a1; req_b1 = b1; req_ctrl1 = c1;
    rsp_ready = 2'b00;
    g = exp_grant(v);
    e = g ? ref_alu(c1, a1, b1) : ref_alu(c0, a0, b0);
    #1;
    check("grant_ready", req_ready, onehot(g));
    check("idle_busy", busy, 1'b0);
    @(negedge clk);
    req_valid = 2'b00;
    req_a0 = $urandom; req_b0 = $urandom; req_a1 = $urandom; req_b1 = $urandom;
    #1;
    check("exec_ready", req_ready, 2'b00);
    check("exec_rsp_valid", rsp_valid, 2'b00);
    check("exec_busy", busy, 1'b1);
    @(negedge clk);
    #1;
    check("resp_valid", rsp_valid, onehot(g));
    check("resp_result", rsp_result, e[35:4]);
    check("resp_flags", rsp_flags, e[3:0]);
  endtask

  task automatic finish_resp(input logic g, input logic [35:0] e, input int stall);
    for (int i = 0; i < stall; i++) begin
      req_valid = 2'b11;
      rsp_ready = onehot(~g);
      @(negedge clk);
      #1;
      check("stall_ready", req_ready, 2'b00);
      check("stall_valid", rsp_valid, onehot(g));
      check("stall_result", rsp_result, e[35:4]);
      check("stall_flags", rsp_flags, e[3:0]);
    end
    req_valid = 2'b00;
    rsp_ready = onehot(g);
    @(negedge clk);
    #1;
    check("drain_valid", rsp_valid, 2'b00);
    check("drain_busy", busy, 1'b0);
    rsp_ready = 2'b00;
    n_done++;
  endtask

  function automatic logic [31:0] pick_operand();
    logic [31:0] specials [5];
    specials[0] = 32'h0000_0000;
    specials[1] = 32'h0000_0001;
    specials[2] = 32'hFFFF_FFFF;
    specials[3] = 32'h8000_0000;
    specials[4] = 32'h7FFF_FFFF;
    if ($urandom_range(0, 2) == 0) return specials[$urandom_range(0, 4)];
    return $urandom;
  endfunction

  initial begin
    logic        g;
    logic [35:0] e;
    rst_n = 1'b0; req_valid = 2'b00; rsp_ready = 2'b00;
    req_a0 = '0; req_b0 = '0; req_a1 = '0; req_b1 = '0;
    req_ctrl0 = '0; req_ctrl1 = '0;

    do_reset();

    // Single add on requester 0
    issue(2'b01, 32'd5, 32'd7, 3'b000, 32'd0, 32'd0, 3'b000, g, e);
    check("add_result", rsp_result, 32'd12);
    check("add_flags", rsp_flags, 4'b0000);
    finish_resp(g, e, 0);

    // Subtraction with borrow, then signed overflow, both on requester 1
    issue(2'b10, 32'd0, 32'd0, 3'b000, 32'd0, 32'd1, 3'b001, g, e);
    check("sub_borrow_result", rsp_result, 32'hFFFF_FFFF);
    check("sub_borrow_flags", rsp_flags, 4'b0100);
    finish_resp(g, e, 0);
    issue(2'b10, 32'd0, 32'd0, 3'b000, 32'h8000_0000, 32'd1, 3'b001, g, e);
    check("sub_ovf_result", rsp_result, 32'h7FFF_FFFF);
    check("sub_ovf_v", rsp_flags[0], 1'b1);
    finish_resp(g, e, 0);

    // Unused ctrl code returns zero
    issue(2'b01, 32'h1234, 32'h5678, 3'b111, 32'd0, 32'd0, 3'b000, g, e);
    check("ctrl111_result", rsp_result, 32'd0);
    finish_resp(g, e, 0);

    // Continuous ties after reset
    do_reset();
    for (int i = 0; i < 4; i++) begin
      issue(2'b11, $urandom, $urandom, 3'b000, $urandom, $urandom, 3'b100, g, e);
`ifdef ALU_SHARE_FIXED_PRIO_EN
      check("tie_seq", g, 1'b0);
`else
      check("tie_seq", g, i[0]);
`endif
      finish_resp(g, e, 0);
    end

    // Backpressure on requester 0 with requester 1 waiting
    do_reset();
    issue(2'b11, 32'd9, 32'd3, 3'b001, 32'd1, 32'd1, 3'b000, g, e);
    finish_resp(g, e, 5);
    issue(2'b11, 32'd9, 32'd3, 3'b001, 32'd1, 32'd1, 3'b000, g, e);
    finish_resp(g, e, 0);

    // Reset while requester 1 holds a response
    do_reset();
    issue(2'b10, 32'd0, 32'd0, 3'b000, 32'd4, 32'd4, 3'b000, g, e);
    req_valid = 2'b11;
    rst_n     = 1'b0;
    #1;
    check("midrst_rsp_valid", rsp_valid, 2'b00);
    check("midrst_req_ready", req_ready, 2'b00);
    check("midrst_result", rsp_result, 32'd0);
    check("midrst_flags", rsp_flags, 4'd0);
    check("midrst_busy", busy, 1'b0);
    @(negedge clk);
    rst_n     = 1'b1;
    req_valid = 2'b00;
    rsp_ready = 2'b11;
    n_done    = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      #1;
      check("postrst_rsp_valid", rsp_valid, 2'b00);
      check("postrst_busy", busy, 1'b0);
    end
    rsp_ready = 2'b00;
    issue(2'b11, 32'd2, 32'd2, 3'b010, 32'd3, 32'd3, 3'b011, g, e);
    check("postrst_grant", g, 1'b0);
    finish_resp(g, e, 0);

    // Random traffic
    for (int i = 0; i < 60; i++) begin
      issue(2'($urandom_range(1, 3)),
            pick_operand(), pick_operand(), 3'($urandom_range(0, 7)),
            pick_operand(), pick_operand(), 3'($urandom_range(0, 7)), g, e);
      finish_resp(g, e, $urandom_range(0, 3));
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
